mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Fourth pipeline stage; sits directly downstream of the execute stage and upstream of write-back.
- Non-memory results: registers the execute-stage result and destination register.
- Loads and stores: performs the data-memory transaction (req/gnt/rvalid) with byte-lane alignment and load sign/zero extension.
- Stalls the upstream stage while a memory access is outstanding.

Parameters:
- WORD_WIDTH, 32, datapath width (from riscv_defines).
- ADDR_WIDTH, 5, register-file address width (from riscv_defines).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  execute stage presents a valid instruction.
- ex_ready_o  out  1  stage can accept an instruction this cycle.
- ex_data_i  in  WORD_WIDTH  execute result; effective address for load/store.
- ex_store_data_i  in  WORD_WIDTH  rs2 value for stores.
- ex_reg_waddr_i  in  ADDR_WIDTH  destination register.
- ex_reg_we_i  in  1  instruction writes rd.
- ex_load_i  in  1  load instruction.
- ex_store_i  in  1  store instruction.
- ex_funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  request accepted.
- data_rvalid_i  in  1  response valid (loads and stores).
- data_addr_o  out  WORD_WIDTH  word-aligned address {addr[31:2],2'b00}.
- data_we_o  out  1  1 = store.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  WORD_WIDTH  lane-replicated store data.
- data_rdata_i  in  WORD_WIDTH  load data.
- wb_valid_o  out  1  one-cycle pulse; write-back result valid.
- wb_data_o  out  WORD_WIDTH  write-back data.
- wb_reg_waddr_o  out  ADDR_WIDTH  destination register.
- wb_reg_we_o  out  1  register write enable.
- lsu_err_o  out  1  one-cycle pulse: misaligned access or illegal funct3.

Behaviour:
- Reset: state IDLE. All registered outputs 0: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, wb_*, lsu_err_o. Reset mid-transaction abandons the access and drops data_req_o immediately.
- FSM states: IDLE, REQ, WAIT_RVALID.
- ex_ready_o = (state == IDLE). Accept = ex_valid_i && ex_ready_o.
- IDLE, non-memory accept: next cycle wb_valid_o = 1, wb_data_o = ex_data_i, wb_reg_we_o = ex_reg_we_i. Latency 1; back-to-back accepts allowed.
- IDLE, ex_load_i and ex_store_i both 1: treated as illegal.
- IDLE, memory accept with legal, aligned access: register addr/we/be/wdata and go to REQ. data_req_o rises the next cycle.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Misaligned or illegal funct3 (011, 110, 111) on a memory op: no request issued. Next cycle wb_valid_o = 1, wb_reg_we_o = 0, lsu_err_o = 1; stay IDLE.
- REQ: hold data_req_o and all data_* stable until data_gnt_i. On gnt: drop req next cycle and go to WAIT_RVALID. data_rvalid_i in REQ is ignored.
- WAIT_RVALID: on data_rvalid_i, next cycle wb_valid_o = 1.
  - Store: wb_reg_we_o = 0.
  - Load: wb_reg_we_o = 1 and wb_data_o = extracted load data.
  - Return to IDLE; ex_ready_o rises in the same cycle as wb_valid_o.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Load extract: shifted = rdata >> (8*addr[1:0]).
  - LB: sign-extend shifted[7].
  - LBU: zero-extend shifted[7:0].
  - LH / LHU: sign- / zero-extend shifted[15:0].
  - LW: rdata unchanged.
- rd = x0: wb_reg_we_o forced 0.

Decomposition:
- riscv_defines package additions:
  - LSU funct3 constants: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
  - Enum mem_state_t {IDLE, REQ, WAIT_RVALID}.
- One combinational sub-module, lsu_align. Inputs: addr[1:0], funct3, store data, rdata. Outputs: be, wdata, load result, misaligned, illegal.
- mem_stage holds the FSM and all registers.

Test Plan:
- ALU op: ex_data_i = 0x1234_5678, rd = 5, we = 1 → next cycle wb_valid_o = 1, wb_data_o = 0x1234_5678, wb_reg_waddr_o = 5, wb_reg_we_o = 1, data_req_o never asserted.
- SB at 0x0000_1003, rs2 = 0xAABB_CCDD, gnt delayed 3 cycles → data_req_o held 3+ cycles with addr 0x0000_1000, be = 1000, wdata = 0xDDDD_DDDD; after rvalid, wb_reg_we_o = 0.
- LB at 0x...02, rdata = 0x0080_0000 → wb_data_o = 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LH at 0x...01 → no data_req_o; next cycle lsu_err_o = 1, wb_valid_o = 1, wb_reg_we_o = 0; funct3 = 011 gives the same response.
- LW, gnt same cycle as req, rvalid 2 cycles later with 0xDEAD_BEEF → ex_ready_o low for the whole access; wb_data_o = 0xDEAD_BEEF; next instruction accepted on the wb_valid_o cycle.
- Assert rst_i while in REQ → data_req_o = 0 and ex_ready_o = 1 without a clock edge; all wb_* outputs = 0.

Source files
------------

// File: rtl/riscv_defines_pkg.sv
// Shared pipeline constants: datapath widths, load/store size encodings and the
// memory-stage FSM states.
package riscv_defines;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RVALID
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads; purely
// combinational, no flow control. Store BU/HU encodings steer like B/H.
module lsu_align (
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);
  import riscv_defines::*;

  logic [31:0] shifted;

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    load_data  = rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    shifted    = rdata >> {addr, 3'b000};

    case (funct3)
      LSU_B, LSU_BU: begin
        be    = 4'b0001 << addr;
        wdata = {4{store_data[7:0]}};
      end
      LSU_H, LSU_HU: begin
        be         = 4'b0011 << addr;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr[0];
      end
      LSU_W: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase

    case (funct3)
      LSU_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_BU:  load_data = {24'h0, shifted[7:0]};
      LSU_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_HU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU results pass through in 1 cycle; loads/stores run a
// req/gnt/rvalid access and stall execute (ex_ready_o low) until the response lands.
module mem_stage #(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int ADDR_WIDTH = riscv_defines::ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [WORD_WIDTH-1:0] ex_data_i,
  input  logic [WORD_WIDTH-1:0] ex_store_data_i,
  input  logic [ADDR_WIDTH-1:0] ex_reg_waddr_i,
  input  logic                  ex_reg_we_i,
  input  logic                  ex_load_i,
  input  logic                  ex_store_i,
  input  logic [2:0]            ex_funct3_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  output logic                  wb_valid_o,
  output logic [WORD_WIDTH-1:0] wb_data_o,
  output logic [ADDR_WIDTH-1:0] wb_reg_waddr_o,
  output logic                  wb_reg_we_o,
  output logic                  lsu_err_o
);
  import riscv_defines::*;

  mem_state_t            state, state_d;
  logic                  req_d, we_d, wb_valid_d, wb_we_d, err_d, ls_load, ls_load_d;
  logic [3:0]            be_d;
  logic [WORD_WIDTH-1:0] addr_d, wdata_d, wb_data_d;
  logic [ADDR_WIDTH-1:0] wb_waddr_d, ls_rd, ls_rd_d;
  logic [1:0]            ls_addr_lo, ls_addr_lo_d, al_addr;
  logic [2:0]            ls_funct3, ls_funct3_d, al_funct3;
  logic [3:0]            al_be;
  logic [31:0]           al_wdata, al_load;
  logic                  al_misaligned, al_illegal, accept;

  // One aligner serves both directions: fed by execute while idle (store lanes,
  // checks) and by the latched access while waiting (load extraction).
  assign al_addr   = (state == IDLE) ? ex_data_i[1:0] : ls_addr_lo;
  assign al_funct3 = (state == IDLE) ? ex_funct3_i    : ls_funct3;

  lsu_align u_align (
    .addr       (al_addr),
    .funct3     (al_funct3),
    .store_data (ex_store_data_i),
    .rdata      (data_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign ex_ready_o = (state == IDLE);
  assign accept     = ex_valid_i && ex_ready_o;

  always_comb begin
    state_d      = state;
    req_d        = data_req_o;
    we_d         = data_we_o;
    be_d         = data_be_o;
    addr_d       = data_addr_o;
    wdata_d      = data_wdata_o;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_o;
    wb_waddr_d   = wb_reg_waddr_o;
    wb_we_d      = 1'b0;
    err_d        = 1'b0;
    ls_load_d    = ls_load;
    ls_rd_d      = ls_rd;
    ls_addr_lo_d = ls_addr_lo;
    ls_funct3_d  = ls_funct3;

    case (state)
      IDLE: begin
        if (accept) begin
          wb_waddr_d = ex_reg_waddr_i;
          if (!ex_load_i && !ex_store_i) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_data_i;
            wb_we_d    = ex_reg_we_i && (ex_reg_waddr_i != '0);
          end else if ((ex_load_i && ex_store_i) || al_illegal || al_misaligned) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            err_d      = 1'b1;
          end else begin
            state_d      = REQ;
            req_d        = 1'b1;
            we_d         = ex_store_i;
            be_d         = al_be;
            addr_d       = {ex_data_i[WORD_WIDTH-1:2], 2'b00};
            wdata_d      = al_wdata;
            ls_load_d    = ex_load_i;
            ls_rd_d      = ex_reg_waddr_i;
            ls_addr_lo_d = ex_data_i[1:0];
            ls_funct3_d  = ex_funct3_i;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          req_d   = 1'b0;
          state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_waddr_d = ls_rd;
          wb_data_d  = ls_load ? al_load : '0;
          wb_we_d    = ls_load && (ls_rd != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      data_req_o     <= 1'b0;
      data_we_o      <= 1'b0;
      data_be_o      <= 4'b0000;
      data_addr_o    <= '0;
      data_wdata_o   <= '0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_reg_waddr_o <= '0;
      wb_reg_we_o    <= 1'b0;
      lsu_err_o      <= 1'b0;
      ls_load        <= 1'b0;
      ls_rd          <= '0;
      ls_addr_lo     <= 2'b00;
      ls_funct3      <= 3'b000;
    end else begin
      state          <= state_d;
      data_req_o     <= req_d;
      data_we_o      <= we_d;
      data_be_o      <= be_d;
      data_addr_o    <= addr_d;
      data_wdata_o   <= wdata_d;
      wb_valid_o     <= wb_valid_d;
      wb_data_o      <= wb_data_d;
      wb_reg_waddr_o <= wb_waddr_d;
      wb_reg_we_o    <= wb_we_d;
      lsu_err_o      <= err_d;
      ls_load        <= ls_load_d;
      ls_rd          <= ls_rd_d;
      ls_addr_lo     <= ls_addr_lo_d;
      ls_funct3      <= ls_funct3_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, store lanes, load extension,
// error responses, stall behaviour and asynchronous reset during an access.
module tb_mem_stage;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_data = '0, ex_store_data = '0;
  logic [4:0]  ex_reg_waddr = '0;
  logic        ex_reg_we = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic        data_req, data_gnt = 1'b0, data_rvalid = 1'b0, data_we;
  logic [31:0] data_addr, data_wdata, data_rdata = '0;
  logic [3:0]  data_be;
  logic        wb_valid, wb_reg_we, lsu_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_waddr;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, ready_leak;
  int          req_cycles, early_wb;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_valid_i      (ex_valid),
    .ex_ready_o      (ex_ready),
    .ex_data_i       (ex_data),
    .ex_store_data_i (ex_store_data),
    .ex_reg_waddr_i  (ex_reg_waddr),
    .ex_reg_we_i     (ex_reg_we),
    .ex_load_i       (ex_load),
    .ex_store_i      (ex_store),
    .ex_funct3_i     (ex_funct3),
    .data_req_o      (data_req),
    .data_gnt_i      (data_gnt),
    .data_rvalid_i   (data_rvalid),
    .data_addr_o     (data_addr),
    .data_we_o       (data_we),
    .data_be_o       (data_be),
    .data_wdata_o    (data_wdata),
    .data_rdata_i    (data_rdata),
    .wb_valid_o      (wb_valid),
    .wb_data_o       (wb_data),
    .wb_reg_waddr_o  (wb_reg_waddr),
    .wb_reg_we_o     (wb_reg_we),
    .lsu_err_o       (lsu_err)
  );

  // Present one instruction for exactly one accepting edge; returns 1 time unit after it.
  task automatic issue(input logic [31:0] data, input logic [31:0] sdata, input logic [2:0] f3,
                       input logic ld, input logic st, input logic [4:0] rd, input logic we);
    ex_valid = 1'b1; ex_data = data; ex_store_data = sdata; ex_funct3 = f3;
    ex_load = ld; ex_store = st; ex_reg_waddr = rd; ex_reg_we = we;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  task automatic observe();
    if (data_req) req_cycles++;
    if (wb_valid) early_wb++;
    if (ex_ready) ready_leak = 1'b1;
  endtask

  // Full memory access; gd = cycles gnt is withheld, rd_dly = idle cycles before rvalid.
  task automatic run_mem(input logic [31:0] addr, input logic [31:0] sdata, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd,
                         input logic [31:0] rdata, input int gd, input int rd_dly, input logic stray);
    issue(addr, sdata, f3, ld, st, rd, 1'b1);
    cap_addr = data_addr; cap_be = data_be; cap_wdata = data_wdata; cap_we = data_we;
    req_cycles = 0; early_wb = 0; ready_leak = 1'b0;
    for (int i = 0; i < gd; i++) begin
      observe();
      if (stray && i == 0) data_rvalid = 1'b1;
      @(posedge clk); #1;
      data_rvalid = 1'b0;
    end
    data_gnt = 1'b1; observe();
    @(posedge clk); #1;
    data_gnt = 1'b0;
    for (int i = 0; i < rd_dly; i++) begin
      observe();
      @(posedge clk); #1;
    end
    data_rvalid = 1'b1; data_rdata = rdata; observe();
    @(posedge clk); #1;
    data_rvalid = 1'b0; data_rdata = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", data_req); end
    checks++; if ({wb_valid, wb_reg_we, lsu_err, data_we} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {wb_valid, wb_reg_we, lsu_err, data_we}); end
    checks++; if ({wb_data, data_addr, data_wdata, data_be, wb_reg_waddr} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {wb_data, data_addr, data_wdata, data_be, wb_reg_waddr}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    issue(32'h1234_5678, 32'h0, LSU_W, 1'b0, 1'b0, 5'd5, 1'b1);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_data got=%h exp=12345678", wb_data); end
    checks++; if (wb_reg_waddr !== 5'd5 || wb_reg_we !== 1'b1) begin errors++; $display("FAIL alu_rd got=%0d/%b exp=5/1", wb_reg_waddr, wb_reg_we); end
    checks++; if (data_req !== 1'b0 || lsu_err !== 1'b0) begin errors++; $display("FAIL alu_noreq got=%b/%b exp=0/0", data_req, lsu_err); end
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_00A1, 32'h0, LSU_W, 1'b0, 1'b0, 5'd6, 1'b1);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hA1) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/000000a1", wb_valid, wb_data); end
    issue(32'h0000_00B2, 32'h0, LSU_W, 1'b0, 1'b0, 5'd0, 1'b1);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hB2) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/000000b2", wb_valid, wb_data); end
    checks++; if (wb_reg_we !== 1'b0) begin errors++; $display("FAIL b2b_x0_we got=%b exp=0", wb_reg_we); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_store_byte();
    run_mem(32'h0000_1003, 32'hAABB_CCDD, LSU_B, 1'b0, 1'b1, 5'd8, 32'h0, 3, 0, 1'b1);
    checks++; if (cap_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got=%h exp=00001000", cap_addr); end
    checks++; if (cap_be !== 4'b1000 || cap_we !== 1'b1) begin errors++; $display("FAIL sb_be_we got=%b/%b exp=1000/1", cap_be, cap_we); end
    checks++; if (cap_wdata !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata got=%h exp=dddddddd", cap_wdata); end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL sb_req_hold got=%0d exp=4", req_cycles); end
    checks++; if (early_wb !== 0 || ready_leak !== 1'b0) begin errors++; $display("FAIL sb_stall got=%0d/%b exp=0/0", early_wb, ready_leak); end
    checks++; if (wb_valid !== 1'b1 || wb_reg_we !== 1'b0) begin errors++; $display("FAIL sb_wb got=%b/%b exp=1/0", wb_valid, wb_reg_we); end
    checks++; if (ex_ready !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL sb_done got=%b/%b exp=1/0", ex_ready, data_req); end
  endtask

  task automatic test_load_extend();
    logic [31:0] exp_data [5];
    logic [2:0]  f3 [5];
    logic [31:0] rdv [5];
    logic [4:0]  rdn [5];
    f3[0] = LSU_B;  rdv[0] = 32'h0080_0000; rdn[0] = 5'd7; exp_data[0] = 32'hFFFF_FF80;
    f3[1] = LSU_BU; rdv[1] = 32'h0080_0000; rdn[1] = 5'd7; exp_data[1] = 32'h0000_0080;
    f3[2] = LSU_H;  rdv[2] = 32'h8001_0000; rdn[2] = 5'd9; exp_data[2] = 32'hFFFF_8001;
    f3[3] = LSU_HU; rdv[3] = 32'h8001_0000; rdn[3] = 5'd9; exp_data[3] = 32'h0000_8001;
    f3[4] = LSU_B;  rdv[4] = 32'h007F_0000; rdn[4] = 5'd0; exp_data[4] = 32'h0000_007F;
    for (int i = 0; i < 5; i++) begin
      run_mem(32'h0000_2002, 32'h0, f3[i], 1'b1, 1'b0, rdn[i], rdv[i], 1, 0, 1'b0);
      checks++; if (wb_valid !== 1'b1 || wb_data !== exp_data[i]) begin errors++; $display("FAIL load_ext[%0d] got=%b/%h exp=1/%h", i, wb_valid, wb_data, exp_data[i]); end
      checks++; if (wb_reg_waddr !== rdn[i] || wb_reg_we !== (rdn[i] != 5'd0)) begin errors++; $display("FAIL load_rd[%0d] got=%0d/%b exp=%0d/%b", i, wb_reg_waddr, wb_reg_we, rdn[i], rdn[i] != 5'd0); end
    end
    checks++; if (cap_be !== 4'b0100 || cap_we !== 1'b0) begin errors++; $display("FAIL load_be got=%b/%b exp=0100/0", cap_be, cap_we); end
  endtask

  task automatic test_error();
    logic [31:0] addr [4];
    logic [2:0]  f3 [4];
    logic        ld [4];
    logic        st [4];
    addr[0] = 32'h0000_0101; f3[0] = LSU_H;  ld[0] = 1'b1; st[0] = 1'b0;
    addr[1] = 32'h0000_0100; f3[1] = 3'b011; ld[1] = 1'b1; st[1] = 1'b0;
    addr[2] = 32'h0000_0102; f3[2] = LSU_W;  ld[2] = 1'b0; st[2] = 1'b1;
    addr[3] = 32'h0000_0100; f3[3] = LSU_W;  ld[3] = 1'b1; st[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(addr[i], 32'h1111_2222, f3[i], ld[i], st[i], 5'd3, 1'b1);
      checks++; if (lsu_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_we !== 1'b0) begin errors++; $display("FAIL err_resp[%0d] got=%b%b%b exp=110", i, lsu_err, wb_valid, wb_reg_we); end
      checks++; if (data_req !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL err_noreq[%0d] got=%b/%b exp=0/1", i, data_req, ex_ready); end
      @(posedge clk); #1;
      checks++; if (lsu_err !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL err_pulse[%0d] got=%b/%b exp=0/0", i, lsu_err, data_req); end
    end
  endtask

  task automatic test_load_word();
    run_mem(32'h0000_3000, 32'h0, LSU_W, 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 0, 1, 1'b0);
    checks++; if (ready_leak !== 1'b0 || req_cycles !== 1) begin errors++; $display("FAIL lw_stall got=%b/%0d exp=0/1", ready_leak, req_cycles); end
    checks++; if (cap_be !== 4'b1111 || cap_addr !== 32'h0000_3000) begin errors++; $display("FAIL lw_req got=%b/%h exp=1111/00003000", cap_be, cap_addr); end
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_reg_we !== 1'b1) begin errors++; $display("FAIL lw_wb got=%b/%h/%b exp=1/deadbeef/1", wb_valid, wb_data, wb_reg_we); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL lw_ready got=%b exp=1", ex_ready); end
    issue(32'h0000_0055, 32'h0, LSU_W, 1'b0, 1'b0, 5'd3, 1'b1);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_reg_waddr !== 5'd3) begin errors++; $display("FAIL lw_next got=%b/%h/%0d exp=1/00000055/3", wb_valid, wb_data, wb_reg_waddr); end
  endtask

  task automatic test_reset_mid();
    issue(32'h0BAD_F00D, 32'h0, LSU_W, 1'b0, 1'b0, 5'd4, 1'b1);
    issue(32'h0000_4000, 32'h0, LSU_W, 1'b1, 1'b0, 5'd10, 1'b1);
    checks++; if (data_req !== 1'b1 || ex_ready !== 1'b0 || wb_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_pre got=%b/%b/%h exp=1/0/0badf00d", data_req, ex_ready, wb_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req got=%b/%b exp=0/1", data_req, ex_ready); end
    checks++; if ({wb_valid, wb_reg_we, wb_reg_waddr, wb_data} !== '0) begin errors++; $display("FAIL rst_mid_wb got=%h exp=0", {wb_valid, wb_reg_we, wb_reg_waddr, wb_data}); end
    checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got=%h exp=0", data_addr); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(32'h0000_0077, 32'h0, LSU_W, 1'b0, 1'b0, 5'd2, 1'b1);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h77 || data_req !== 1'b0) begin errors++; $display("FAIL rst_recover got=%b/%h/%b exp=1/00000077/0", wb_valid, wb_data, data_req); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_store_byte();
    test_load_extend();
    test_error();
    test_load_word();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
